// File: rtl/auth_session_ctrl.sv
// Front-panel login controller: role decode on confirm, session hold with idle logout,
// permission-checked feature latch, and failed-login lockout.
module auth_session_ctrl #(
  parameter int unsigned         NUM_FEAT   = 7,
  parameter int unsigned         FEAT_W     = 3,
  parameter logic [NUM_FEAT-1:0] ADM_MASK   = 7'h7F,
  parameter logic [NUM_FEAT-1:0] TEST_MASK  = 7'h3F,
  parameter logic [NUM_FEAT-1:0] USER_MASK  = 7'h0F,
  parameter logic [NUM_FEAT-1:0] GUEST_MASK = 7'h01,
  parameter int unsigned         MAX_FAIL   = 3,
  parameter int unsigned         LOCK_CYC   = 16,
  parameter int unsigned         IDLE_CYC   = 1024,
  localparam int unsigned        FAIL_W     = $clog2(MAX_FAIL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ch_role,
  input  logic                bt0,
  input  logic                bt1,
  input  logic                bt_confirm,
  input  logic                bt_sel,
  input  logic                bt_logout,
  input  logic [FEAT_W-1:0]   feat_code,
  output logic [3:0]          role_oh,
  output logic                session,
  output logic                locked,
  output logic [NUM_FEAT-1:0] feat_oh,
  output logic                deny,
  output logic [FAIL_W-1:0]   fail_cnt
);

  localparam int unsigned LCNT_W = $clog2(LOCK_CYC + 1);
  localparam int unsigned ICNT_W = $clog2(IDLE_CYC + 1);

  typedef enum logic [1:0] {StIdle, StSession, StLocked} state_e;

  state_e              state_q, state_d;
  logic [3:0]          role_q, role_d;
  logic [NUM_FEAT-1:0] feat_q, feat_d;
  logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
  logic                deny_q, deny_d;
  logic [LCNT_W-1:0]   lock_q, lock_d;
  logic [ICNT_W-1:0]   idle_q, idle_d;
  logic                conf_prev_q, sel_prev_q, logout_prev_q;

  logic                conf_ev, sel_ev, logout_ev, any_ev;
  logic [3:0]          role_dec;
  logic [NUM_FEAT-1:0] mask, sel_oh;
  logic                sel_ok;

  assign conf_ev   = bt_confirm & ~conf_prev_q;
  assign sel_ev    = bt_sel & ~sel_prev_q;
  assign logout_ev = bt_logout & ~logout_prev_q;
  assign any_ev    = conf_ev | sel_ev | logout_ev;
  assign fail_inc  = fail_q + FAIL_W'(1);

  // role_dec bit order {guest,user,test,adm}; zero means invalid combination
  always_comb begin
    role_dec = 4'b0000;
    case ({ch_role, bt0, bt1})
      3'b101:  role_dec = 4'b0001;
      3'b011:  role_dec = 4'b0010;
      3'b001:  role_dec = 4'b0100;
      3'b110:  role_dec = 4'b1000;
      default: role_dec = 4'b0000;
    endcase
  end

  always_comb begin
    mask = '0;
    case (role_q)
      4'b0001: mask = ADM_MASK;
      4'b0010: mask = TEST_MASK;
      4'b0100: mask = USER_MASK;
      4'b1000: mask = GUEST_MASK;
      default: mask = '0;
    endcase
    // Codes above NUM_FEAT leave sel_oh zero and therefore fail the permission check
    sel_oh = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      if (feat_code == FEAT_W'(i + 1)) sel_oh[i] = 1'b1;
    end
    sel_ok = |(sel_oh & mask);
  end

  always_comb begin
    state_d = state_q;
    role_d  = role_q;
    feat_d  = feat_q;
    fail_d  = fail_q;
    deny_d  = 1'b0;
    lock_d  = lock_q;
    idle_d  = idle_q;
    case (state_q)
      StIdle: begin
        if (conf_ev) begin
          if (|role_dec) begin
            state_d = StSession;
            role_d  = role_dec;
            fail_d  = '0;
            feat_d  = '0;
            idle_d  = '0;
          end else begin
            deny_d = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
              state_d = StLocked;
              lock_d  = '0;
            end
          end
        end
      end
      StSession: begin
        if (logout_ev) begin
          state_d = StIdle;
          role_d  = '0;
          feat_d  = '0;
          idle_d  = '0;
        end else if (!any_ev) begin
          if (idle_q == ICNT_W'(IDLE_CYC - 1)) begin
            state_d = StIdle;
            role_d  = '0;
            feat_d  = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + ICNT_W'(1);
          end
        end else begin
          idle_d = '0;
          if (sel_ev) begin
            if (feat_code == '0) feat_d = '0;
            else if (sel_ok)     feat_d = sel_oh;
            else                 deny_d = 1'b1;
          end
        end
      end
      StLocked: begin
        if (lock_q == LCNT_W'(LOCK_CYC - 1)) begin
          state_d = StIdle;
          fail_d  = '0;
          lock_d  = '0;
        end else begin
          lock_d = lock_q + LCNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      role_q        <= '0;
      feat_q        <= '0;
      fail_q        <= '0;
      deny_q        <= 1'b0;
      lock_q        <= '0;
      idle_q        <= '0;
      // Held buttons must not look like fresh presses after reset
      conf_prev_q   <= 1'b1;
      sel_prev_q    <= 1'b1;
      logout_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      role_q        <= role_d;
      feat_q        <= feat_d;
      fail_q        <= fail_d;
      deny_q        <= deny_d;
      lock_q        <= lock_d;
      idle_q        <= idle_d;
      conf_prev_q   <= bt_confirm;
      sel_prev_q    <= bt_sel;
      logout_prev_q <= bt_logout;
    end
  end

  assign role_oh  = role_q;
  assign session  = (state_q == StSession);
  assign locked   = (state_q == StLocked);
  assign feat_oh  = feat_q;
  assign deny     = deny_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_auth_session_ctrl.sv
// Directed bench for auth_session_ctrl: vector table for single-cycle behaviour plus
// hand sequences for lockout, idle timeout and reset corner cases.
module tb_auth_session_ctrl;

  logic       clk, rst;
  logic       ch_role, bt0, bt1, bt_confirm, bt_sel, bt_logout;
  logic [2:0] feat_code;
  logic [3:0] role_oh;
  logic       session, locked, deny;
  logic [6:0] feat_oh;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  auth_session_ctrl #(.IDLE_CYC(8)) dut (
    .clk(clk), .rst(rst), .ch_role(ch_role), .bt0(bt0), .bt1(bt1),
    .bt_confirm(bt_confirm), .bt_sel(bt_sel), .bt_logout(bt_logout),
    .feat_code(feat_code), .role_oh(role_oh), .session(session), .locked(locked),
    .feat_oh(feat_oh), .deny(deny), .fail_cnt(fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       conf, sel, logout;
    logic [2:0] rin;
    logic [2:0] code;
    logic [3:0] e_role;
    logic       e_sess, e_lock;
    logic [6:0] e_feat;
    logic       e_deny;
    logic [1:0] e_fail;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic s, logic l, logic [2:0] r, logic [2:0] k,
                              logic [3:0] er, logic es, logic el, logic [6:0] ef,
                              logic ed, logic [1:0] efl);
    vec_t v;
    v.conf = c; v.sel = s; v.logout = l; v.rin = r; v.code = k;
    v.e_role = er; v.e_sess = es; v.e_lock = el; v.e_feat = ef; v.e_deny = ed; v.e_fail = efl;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic c, logic s, logic l, logic [2:0] r, logic [2:0] k);
    bt_confirm = c; bt_sel = s; bt_logout = l;
    {ch_role, bt0, bt1} = r;
    feat_code = k;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [3:0] er, logic es, logic el, logic [6:0] ef,
                         logic ed, logic [1:0] efl);
    chk({tag, "_role"}, 32'(role_oh), 32'(er));
    chk({tag, "_sess"}, 32'(session), 32'(es));
    chk({tag, "_lock"}, 32'(locked), 32'(el));
    chk({tag, "_feat"}, 32'(feat_oh), 32'(ef));
    chk({tag, "_deny"}, 32'(deny), 32'(ed));
    chk({tag, "_fail"}, 32'(fail_cnt), 32'(efl));
  endtask

  initial begin
    // conf sel logout rin code | role sess lock feat deny fail
    vecs.push_back(mk(0,0,0,3'b000,0, 4'b0000,0,0,7'b0000000,0,0));
    vecs.push_back(mk(1,0,0,3'b001,0, 4'b0100,1,0,7'b0000000,0,0));
    vecs.push_back(mk(0,1,0,3'b001,3, 4'b0100,1,0,7'b0000100,0,0));
    vecs.push_back(mk(0,0,0,3'b001,6, 4'b0100,1,0,7'b0000100,0,0));
    vecs.push_back(mk(0,1,0,3'b001,6, 4'b0100,1,0,7'b0000100,1,0));
    vecs.push_back(mk(0,0,0,3'b001,6, 4'b0100,1,0,7'b0000100,0,0));
    vecs.push_back(mk(0,1,0,3'b000,0, 4'b0100,1,0,7'b0000000,0,0));
    vecs.push_back(mk(0,0,0,3'b000,2, 4'b0100,1,0,7'b0000000,0,0));
    vecs.push_back(mk(0,1,0,3'b000,2, 4'b0100,1,0,7'b0000010,0,0));
    vecs.push_back(mk(0,0,1,3'b000,2, 4'b0000,0,0,7'b0000000,0,0));
    vecs.push_back(mk(1,0,0,3'b010,0, 4'b0000,0,0,7'b0000000,1,1));
    vecs.push_back(mk(0,0,0,3'b010,0, 4'b0000,0,0,7'b0000000,0,1));
    vecs.push_back(mk(1,0,0,3'b110,0, 4'b1000,1,0,7'b0000000,0,0));
    vecs.push_back(mk(0,1,0,3'b110,2, 4'b1000,1,0,7'b0000000,1,0));
    vecs.push_back(mk(0,0,0,3'b110,1, 4'b1000,1,0,7'b0000000,0,0));
    vecs.push_back(mk(0,1,0,3'b110,1, 4'b1000,1,0,7'b0000001,0,0));
    vecs.push_back(mk(0,0,1,3'b110,1, 4'b0000,0,0,7'b0000000,0,0));
    vecs.push_back(mk(1,0,0,3'b101,0, 4'b0001,1,0,7'b0000000,0,0));
    vecs.push_back(mk(0,1,0,3'b101,7, 4'b0001,1,0,7'b1000000,0,0));
    vecs.push_back(mk(1,0,0,3'b110,0, 4'b0001,1,0,7'b1000000,0,0));
    vecs.push_back(mk(0,0,0,3'b000,1, 4'b0001,1,0,7'b1000000,0,0));
    vecs.push_back(mk(0,1,1,3'b000,1, 4'b0000,0,0,7'b0000000,0,0));
    vecs.push_back(mk(0,0,0,3'b000,0, 4'b0000,0,0,7'b0000000,0,0));
    vecs.push_back(mk(1,0,0,3'b011,0, 4'b0010,1,0,7'b0000000,0,0));
    vecs.push_back(mk(0,1,0,3'b011,7, 4'b0010,1,0,7'b0000000,1,0));
    vecs.push_back(mk(0,0,1,3'b011,0, 4'b0000,0,0,7'b0000000,0,0));
    vecs.push_back(mk(0,0,0,3'b000,0, 4'b0000,0,0,7'b0000000,0,0));

    rst = 1'b1;
    set_in(0, 0, 0, 3'b000, 0);
    tick();
    chk_all("reset", 4'b0000, 0, 0, 7'b0, 0, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      set_in(vecs[i].conf, vecs[i].sel, vecs[i].logout, vecs[i].rin, vecs[i].code);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_role, vecs[i].e_sess, vecs[i].e_lock,
              vecs[i].e_feat, vecs[i].e_deny, vecs[i].e_fail);
    end

    // Lockout: three failed confirms, then LOCK_CYC locked cycles ignoring presses
    for (int k = 1; k <= 3; k++) begin
      set_in(1, 0, 0, 3'b010, 0);
      tick();
      chk_all($sformatf("fail%0d", k), 4'b0000, 0, (k == 3), 7'b0, 1, 2'(k));
      if (k < 3) begin
        set_in(0, 0, 0, 3'b010, 0);
        tick();
        chk_all($sformatf("fail%0d_rel", k), 4'b0000, 0, 0, 7'b0, 0, 2'(k));
      end
    end
    for (int j = 2; j <= 16; j++) begin
      set_in(1'(j % 2), 0, 0, 3'b101, 0);
      tick();
      chk_all($sformatf("lock%0d", j), 4'b0000, 0, 1, 7'b0, 0, 3);
    end
    set_in(0, 0, 0, 3'b000, 0);
    tick();
    chk_all("lock_exit", 4'b0000, 0, 0, 7'b0, 0, 0);

    // Idle timeout with IDLE_CYC=8: session high for 8 cycles after login event
    set_in(1, 0, 0, 3'b001, 0);
    tick();
    chk("to_login", 32'(session), 32'd1);
    set_in(0, 0, 0, 3'b001, 0);
    for (int t = 2; t <= 8; t++) begin
      tick();
      chk($sformatf("to_hold%0d", t), 32'(session), 32'd1);
    end
    tick();
    chk_all("to_expire", 4'b0000, 0, 0, 7'b0, 0, 0);

    // A sel event restarts the idle count
    set_in(1, 0, 0, 3'b001, 0);
    tick();
    set_in(0, 0, 0, 3'b001, 0);
    for (int t = 2; t <= 5; t++) tick();
    chk("rs_s5", 32'(session), 32'd1);
    set_in(0, 1, 0, 3'b001, 0);
    tick();
    chk("rs_s6", 32'(session), 32'd1);
    set_in(0, 0, 0, 3'b001, 0);
    for (int t = 7; t <= 13; t++) begin
      tick();
      chk($sformatf("rs_hold%0d", t), 32'(session), 32'd1);
    end
    tick();
    chk("rs_expire", 32'(session), 32'd0);

    // Reset mid-lockout
    for (int k = 1; k <= 3; k++) begin
      set_in(1, 0, 0, 3'b000, 0);
      tick();
      set_in(0, 0, 0, 3'b000, 0);
      tick();
    end
    chk("rl_locked", 32'(locked), 32'd1);
    rst = 1'b1;
    tick();
    chk_all("rst_lock", 4'b0000, 0, 0, 7'b0, 0, 0);
    rst = 1'b0;
    tick();

    // Reset mid-session with a feature latched
    set_in(1, 0, 0, 3'b101, 0);
    tick();
    set_in(0, 1, 0, 3'b101, 5);
    tick();
    chk_all("rs_pre", 4'b0001, 1, 0, 7'b0010000, 0, 0);
    set_in(0, 0, 0, 3'b000, 0);
    rst = 1'b1;
    tick();
    chk_all("rst_sess", 4'b0000, 0, 0, 7'b0, 0, 0);
    rst = 1'b0;

    // Confirm held through reset is not an event; a fresh press is
    set_in(1, 0, 0, 3'b101, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk_all("held_conf", 4'b0000, 0, 0, 7'b0, 0, 0);
    set_in(0, 0, 0, 3'b101, 0);
    tick();
    set_in(1, 0, 0, 3'b101, 0);
    tick();
    chk_all("repress", 4'b0001, 1, 0, 7'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
